// File: rtl/rv_pkg.sv
// Shared front-end definitions: canonical NOP, fetch FSM state encoding and the
// {pc, inst} entry carried from instruction fetch toward IF/DE.
package rv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2,
        FS_FULL = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_buf.sv
// Small shift-style FIFO (depth 1 or 2) of fetched {pc, inst} entries; head is slot 0.
module if_fetch_buf
    import rv_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q   [DEPTH];
    fetch_entry_t  mem_d   [DEPTH];
    fetch_entry_t  shifted [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d, wr_idx;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
        if (gi == DEPTH - 1) begin : g_last
            assign shifted[gi] = '0;
        end else begin : g_mid
            assign shifted[gi] = mem_q[gi + 1];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = pop ? shifted[i] : mem_q[i];
        end
        // a simultaneous pop moves the tail down first, so the write lands one slot lower
        wr_idx = cnt_q - CW'(pop);
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    mem_d[i] = push_data;
                end
            end
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[0];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one-at-a-time imem requests and feeds IF/DE.
// Build option IF_SKID_EN: 2-entry skid buffer; undefined: 1-entry holding register.
//
// state | meaning
// IDLE  | no request; next edge issues at fetch_pc (entered on reset or redirect+ack)
// REQ   | request at imem_addr outstanding; ack pushes the word
// DROP  | request outstanding whose word is discarded; ack refetches at fetch_pc
// FULL  | buffer full, no request; a pop re-enters REQ
module if_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master imem,
    input  logic            stall,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic [31:0]     inst_out,
    output logic [31:0]     pc_out,
    output logic            inst_valid
);

`ifdef IF_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [1:0] ST_IDLE = FS_IDLE;
    localparam logic [1:0] ST_REQ  = FS_REQ;
    localparam logic [1:0] ST_DROP = FS_DROP;

    logic [1:0]   state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         ack_v, push, pop, full, empty, room;
    logic [1:0]   level, level_nxt;
    fetch_entry_t head, push_data;

    assign imem.imem_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign imem.imem_addr = addr_q;

    assign ack_v     = imem.imem_ack && imem.imem_req;
    assign push      = ack_v && (state_q == ST_REQ) && !redirect;
    assign pop       = !empty && !stall && !redirect;
    assign push_data = '{pc: addr_q, inst: imem.imem_rdata};

    assign level     = full ? 2'(DEPTH) : (empty ? 2'd0 : 2'd1);
    assign level_nxt = level + {1'b0, push} - {1'b0, pop};
    // a redirect flushes the buffer, so it always leaves room
    assign room      = redirect || (level_nxt < 2'(DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    state_d = ack_v ? ST_IDLE : ST_DROP;
                end else if (ack_v) begin
                    state_d = room ? ST_REQ : FS_FULL;
                end
            end
            ST_DROP: begin
                if (ack_v) begin
                    state_d = redirect ? ST_IDLE : ST_REQ;
                end
            end
            default: begin
                if (room) begin
                    state_d = ST_REQ;
                end
            end
        endcase

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
        // the dropped request keeps its address on the bus until its ack arrives
        addr_d = (state_d == ST_DROP) ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    if_fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign inst_valid = !empty;
    assign inst_out   = empty ? NOP_INST : head.inst;
    assign pc_out     = empty ? fetch_pc_q : head.pc;

endmodule
